// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit period and 8N1 frame shape.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // 50 MHz system clock at 115200 Bd
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; width and reset level are parameters.
module sync_2ff #(
    parameter int                WIDTH       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: deframes the RX pin, strobes each good byte and flags bad stop bits.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] BYTE_output,
    output logic       byte_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);
    localparam logic [2:0]     LAST_IDX = 3'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
            $error("uart_byte_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    logic                 rx_s;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shreg;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk (CLK),
        .rst (RST),
        .d   (RX),
        .q   (rx_s)
    );

    // Samples land mid-bit: start bit after HALF, then every full bit period from there.
    // Returning to IDLE mid stop bit leaves time to catch a back-to-back start edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            BYTE_output <= 8'h00;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        idx <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        idx   <= idx + 3'd1;
                        if (idx == LAST_IDX) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            BYTE_output <= shreg;
                            byte_valid  <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial-to-byte receiver at the front of the 12-channel link. It samples the asynchronous RX pin, deframes standard 8N1 UART characters (LSB first), and presents each good byte with a one-cycle strobe. The strobe drives the `transmission_start` input of the downstream packet validator (`FF FE D0 D1 CRC`). Framing faults are reported separately, and a bad character is never forwarded.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200 Bd): clock cycles per bit. Legal range is ≥ 4; elaboration fails otherwise.
- `CLK`  in  1  system clock; everything runs on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `RX`  in  1  asynchronous serial line; idles high.
- `BYTE_output`  out  8  last good byte received; holds its value between strobes.
- `byte_valid`  out  1  one-cycle pulse when `BYTE_output` is updated. Connects to the validator's `transmission_start`.
- `frame_error`  out  1  one-cycle pulse when the stop bit samples low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `RX` passes through a 2-flop synchronizer. Both flops reset to 1. The second flop's output is `rx_s`.
- `H = (CLKS_PER_BIT-1)/2` (integer division). The bit counter is `$clog2(CLKS_PER_BIT)` bits wide, and the bit index is 3 bits wide.
- **IDLE**
  - `rx_s == 0` → START; counter cleared.
- **START**
  - The counter runs up to H, then `rx_s` is sampled (mid start bit).
  - Sample = 0 → DATA; counter and index cleared.
  - Sample = 1 → IDLE (glitch rejected). No output activity.
- **DATA**
  - Each bit is sampled when the counter reaches `CLKS_PER_BIT-1`; the counter then clears.
  - The sample shifts into a shift register, LSB first.
  - After the sample at index 7 → STOP.
- **STOP**
  - The counter runs to `CLKS_PER_BIT-1`, then `rx_s` is sampled.
  - Sample = 1 → the shift register is copied to `BYTE_output`, `byte_valid` pulses, and the FSM returns to IDLE. IDLE is entered mid stop bit so that back-to-back characters are caught.
  - Sample = 0 → `frame_error` pulses, `BYTE_output` is unchanged, and the FSM goes to WAIT_HIGH.
- **WAIT_HIGH**
  - Stays here while `rx_s == 0` (line break).
  - `rx_s == 1` → IDLE. A break therefore yields exactly one `frame_error` and no spurious bytes.
- `byte_valid` and `frame_error` are never high in the same cycle, and neither is ever high for two consecutive cycles.
- The block has no back-pressure. The consumer must accept a byte in the strobe cycle. The minimum strobe spacing is about `9.5*CLKS_PER_BIT` cycles.

## Timing
- **Reset values:** `BYTE_output` = 8'h00, `byte_valid` = 0, `frame_error` = 0, `busy` = 0. State = IDLE, synchronizer = 1.
- **Reset mid-frame:** the partial character is discarded, with no strobe on the cycle reset is applied or afterwards. The line is re-armed from IDLE.
- **Cycle numbering:** cycle 0 is the edge at which IDLE sees `rx_s == 0`. This is 2 cycles after the pin's falling edge is registered.
- **Sample points, counted from cycle 0:**
  - Start bit: H+1.
  - Data bit k (k = 0..7): H+1+(k+1)·CLKS_PER_BIT.
  - Stop bit: H+1+9·CLKS_PER_BIT.
- **Strobes:** `byte_valid` or `frame_error` is high in the cycle directly after the stop sample edge (registered output).
- **busy:** rises the cycle after cycle 0. It falls together with the `byte_valid` pulse, or on WAIT_HIGH exit.
- **Baud tolerance:** ±3 % clock mismatch must still decode, since every sample lands mid-bit.

## Structure
- Shared package `uart_pkg`:
  - state encodings IDLE/START/DATA/STOP/WAIT_HIGH (3 bits);
  - the default `CLKS_PER_BIT` constant;
  - the 8N1 frame constants `DATA_BITS = 8` and `STOP_BITS = 1`.
- One sub-module, `sync_2ff`: a parameterized-width 2-flop synchronizer with a reset value parameter. It is reused for other asynchronous inputs on the board.
- The FSM, counters, shift register and output registers live in `uart_byte_rx`. Target size is about 150 lines.

## Test plan
- **Single byte:** `CLKS_PER_BIT=16`, byte 0xA5 (LSB first) → exactly one `byte_valid` pulse with `BYTE_output=8'hA5`, at cycle H+1+9·16+1 from the detected start; `frame_error` stays 0.
- **Glitch:** RX low for 3 cycles in idle → no `byte_valid`, no `frame_error`; `busy` pulses briefly and returns to 0 within H+2 cycles.
- **Bad stop bit:** 0x3C sent with stop bit = 0 → one `frame_error` pulse, no `byte_valid`, `BYTE_output` keeps its previous value. A following 0x55 is then received correctly.
- **Break:** RX held low for 40 bit times, then released → exactly one `frame_error`, zero `byte_valid`. The next 0x81 is received correctly.
- **Back-to-back packet:** FF FE 12 34 26, no idle gap, at `CLKS_PER_BIT=434` → five `byte_valid` pulses in order, 10·434 cycles apart. The downstream validator latches PORT1=0x12 and PORT2=0x34.
- **Reset mid-frame:** `RST` asserted for 1 cycle during data bit 4 of 0xF0 → no strobe; outputs return to their reset values. The next complete 0x0F yields `BYTE_output=8'h0F`.
